pcm_packetizer: RTL and testbench
=================================

PCM_PACKETIZER -- requirements
Module: pcm_packetizer

Interface
REQ-001 SHALL have parameter SAMPLES_PER_PKT, default 32, samples per packet, legal range 1..255.
REQ-002 SHALL have parameter SYNC0, default 8'hA5, first sync byte.
REQ-003 SHALL have parameter SYNC1, default 8'h5A, second sync byte.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port enable_i, input, 1, packetizing enabled.
REQ-007 SHALL have port pcm_data_i, input, 16, signed PCM sample from the I2S receiver, already synchronized to clk.
REQ-008 SHALL have port pcm_valid_i, input, 1, single-cycle strobe qualifying pcm_data_i.
REQ-009 SHALL have port fifo_full_i, input, 1, downstream byte FIFO full.
REQ-010 SHALL have port fifo_wr_en_o, output, 1, byte write strobe to the FIFO.
REQ-011 SHALL have port fifo_data_o, output, 8, byte presented with fifo_wr_en_o.
REQ-012 SHALL have port seq_o, output, 8, sequence number of the next packet.
REQ-013 SHALL have port drop_count_o, output, 16, saturating count of dropped samples.
REQ-014 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-015 Packet format SHALL be: SYNC0, SYNC1, SEQ, LEN(=SAMPLES_PER_PKT), then per sample low byte then high byte, then CSUM.
REQ-016 CSUM SHALL be the modulo-256 sum of SEQ, LEN and all payload bytes; sync bytes excluded.
REQ-017 FSM states SHALL be IDLE, SYNC0, SYNC1, SEQ, LEN, PAY_LO, PAY_HI, CSUM.
REQ-018 A one-entry holding register SHALL capture pcm_data_i on pcm_valid_i when enable_i is high and the register is empty or being emptied this cycle.
REQ-019 A pcm_valid_i arriving while the holding register is full and not being emptied this cycle SHALL be dropped and drop_count_o incremented, saturating at 16'hFFFF.
REQ-020 pcm_valid_i while enable_i is low and state is IDLE SHALL be discarded without counting.
REQ-021 IDLE SHALL move to SYNC0 when enable_i is high and the holding register is full.
REQ-022 In every non-IDLE state, fifo_wr_en_o SHALL equal (byte available) AND NOT fifo_full_i combinationally; the state advances only on a cycle with fifo_wr_en_o high.
REQ-023 fifo_data_o SHALL be stable and valid in every cycle fifo_wr_en_o is high; fifo_wr_en_o SHALL never be high while fifo_full_i is high.
REQ-024 PAY_LO SHALL stall, with no write, while the holding register is empty; PAY_HI writing the high byte SHALL empty the holding register.
REQ-025 The sample counter SHALL advance after PAY_HI; after SAMPLES_PER_PKT samples, PAY_HI SHALL go to CSUM, otherwise to PAY_LO.
REQ-026 CSUM write SHALL increment seq_o (8'hFF wraps to 8'h00), clear the checksum accumulator and go to IDLE.
REQ-027 Deassertion of enable_i mid-packet SHALL NOT abort; the packet completes, and samples still arriving are held or dropped normally until IDLE.
REQ-028 Simultaneous pcm_valid_i and PAY_HI consume SHALL load the new sample with no drop.

Reset
REQ-029 On rst_n low at a clk edge: state IDLE, holding register empty, seq_o 0, drop_count_o 0, checksum 0, sample counter 0.
REQ-030 During and immediately after reset, fifo_wr_en_o SHALL be 0, busy_o 0, fifo_data_o 8'h00.
REQ-031 Reset mid-packet SHALL abandon the partial packet with no further writes.

Structure
REQ-032 State enum and default sync constants SHALL live in shared package pcm_pkt_pkg.
REQ-033 The block SHALL be a single module with no sub-module; checksum, counters and holding register are inline.

Verification
REQ-034 SAMPLES_PER_PKT=2, fifo_full_i=0, samples 16'h1234, 16'h5678 -> bytes A5 5A 00 02 34 12 78 56 16; seq_o becomes 1.
REQ-035 Same stimulus, fifo_full_i held high 5 cycles at the LEN byte -> no write while full, identical byte stream, no drops if no sample arrives meanwhile.
REQ-036 fifo_full_i held high, three pcm_valid_i strobes while holding register full -> drop_count_o=3; preload 16'hFFFF, further drop -> stays 16'hFFFF.
REQ-037 256 packets sent -> SEQ byte of packet 257 is 8'h00.
REQ-038 enable_i dropped after the first payload byte -> packet completes with correct CSUM, then IDLE; busy_o falls after the CSUM write.
REQ-039 rst_n low during PAY_HI -> no further writes; outputs equal reset values on the next cycle; the next packet starts with SEQ 8'h00.

Source files
------------

// File: rtl/pcm_pkt_pkg.sv
// pcm_pkt_pkg: shared FSM state encoding and default sync bytes for the PCM packetizer
package pcm_pkt_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC0, ST_SYNC1, ST_SEQ, ST_LEN, ST_PAY_LO, ST_PAY_HI, ST_CSUM
  } state_t;
  localparam logic [7:0] DEF_SYNC0 = 8'hA5;
  localparam logic [7:0] DEF_SYNC1 = 8'h5A;
endpackage

// File: rtl/pcm_packetizer.sv
// pcm_packetizer: frames 16-bit PCM samples into sync/seq/len/payload/checksum byte packets
module pcm_packetizer
  import pcm_pkt_pkg::*;
#(
  parameter int         SAMPLES_PER_PKT = 32,
  parameter logic [7:0] SYNC0           = DEF_SYNC0,
  parameter logic [7:0] SYNC1           = DEF_SYNC1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [15:0] pcm_data_i,
  input  logic        pcm_valid_i,
  input  logic        fifo_full_i,
  output logic        fifo_wr_en_o,
  output logic [7:0]  fifo_data_o,
  output logic [7:0]  seq_o,
  output logic [15:0] drop_count_o,
  output logic        busy_o
);
  state_t      state, state_nx;
  logic        hold_full, avail, wr, consume, accept, last;
  logic [15:0] hold_data, drops;
  logic [7:0]  seq, csum, cnt, byte_d;
  always_comb begin
    avail    = (state == ST_PAY_LO) ? hold_full : (state != ST_IDLE);
    wr       = rst_n && avail && !fifo_full_i;
    consume  = wr && (state == ST_PAY_HI);
    // once a packet is under way, samples are still accepted even with enable low
    accept   = pcm_valid_i && (enable_i || state != ST_IDLE);
    last     = cnt == 8'(SAMPLES_PER_PKT - 1);
    byte_d   = 8'h00;
    case (state)
      ST_SYNC0:  byte_d = SYNC0;
      ST_SYNC1:  byte_d = SYNC1;
      ST_SEQ:    byte_d = seq;
      ST_LEN:    byte_d = 8'(SAMPLES_PER_PKT);
      ST_PAY_LO: byte_d = hold_data[7:0];
      ST_PAY_HI: byte_d = hold_data[15:8];
      ST_CSUM:   byte_d = csum;
      default:   byte_d = 8'h00;
    endcase
    // CSUM is last in the encoding, so +1 wraps it back to IDLE
    state_nx = (state == ST_IDLE) ? ((enable_i && hold_full) ? ST_SYNC0 : ST_IDLE) :
               !wr ? state :
               (state == ST_PAY_HI) ? (last ? ST_CSUM : ST_PAY_LO) :
               state_t'(state + 3'd1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      hold_data <= 16'h0000;
      seq       <= 8'h00;
      drops     <= 16'h0000;
      csum      <= 8'h00;
      cnt       <= 8'h00;
    end else begin
      state <= state_nx;
      if (accept && (!hold_full || consume)) begin
        hold_full <= 1'b1;
        hold_data <= pcm_data_i;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
      if (accept && hold_full && !consume && drops != 16'hFFFF)
        drops <= drops + 16'd1;
      if (wr && state == ST_CSUM)
        csum <= 8'h00;
      else if (wr && state >= ST_SEQ)
        csum <= csum + byte_d;
      if (consume)
        cnt <= last ? 8'h00 : cnt + 8'd1;
      if (wr && state == ST_CSUM)
        seq <= seq + 8'd1;
    end
  end
  assign fifo_wr_en_o = wr;
  assign fifo_data_o  = rst_n ? byte_d : 8'h00;
  assign seq_o        = seq;
  assign drop_count_o = drops;
  assign busy_o       = rst_n && (state != ST_IDLE);
endmodule

// File: tb/tb_pcm_packetizer.sv
// tb_pcm_packetizer: directed table-driven bench for pcm_packetizer with SAMPLES_PER_PKT=2
module tb_pcm_packetizer;
  logic        clk = 1'b0;
  logic        rst_n, enable, pcm_valid, fifo_full;
  logic [15:0] pcm_data;
  logic        fifo_wr_en, busy;
  logic [7:0]  fifo_data, seq;
  logic [15:0] drop_count;
  int          checks = 0;
  int          failures = 0;
  int          viol = 0;
  logic [7:0]  q[$];

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    logic [7:0]  csum;
  } vec_t;
  vec_t tbl[5];

  pcm_packetizer #(.SAMPLES_PER_PKT(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .pcm_data_i(pcm_data),
    .pcm_valid_i(pcm_valid), .fifo_full_i(fifo_full), .fifo_wr_en_o(fifo_wr_en),
    .fifo_data_o(fifo_data), .seq_o(seq), .drop_count_o(drop_count), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      q.push_back(fifo_data);
      if (fifo_full) viol++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (q.size() < n && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (q.size() < n) chk("wait_bytes_timeout", 32'(q.size()), 32'(n));
  endtask

  task automatic pulse(input logic [15:0] s);
    pcm_valid = 1'b1;
    pcm_data  = s;
    @(posedge clk);
    #1 pcm_valid = 1'b0;
  endtask

  // mode 0: plain; mode 1: FIFO full for 5 cycles at LEN; mode 2: enable dropped after first payload byte
  task automatic run_pkt(input logic [15:0] s0, input logic [15:0] s1,
                         input logic [7:0] sq, input logic [7:0] cs, input int mode);
    logic [7:0] exp [9];
    logic [7:0] nsq;
    exp[0] = 8'hA5; exp[1] = 8'h5A; exp[2] = sq; exp[3] = 8'h02;
    exp[4] = s0[7:0]; exp[5] = s0[15:8]; exp[6] = s1[7:0]; exp[7] = s1[15:8]; exp[8] = cs;
    nsq = sq + 8'd1;
    q.delete();
    enable = 1'b1;
    pulse(s0);
    if (mode == 1) begin
      wait_bytes(3);
      @(posedge clk);
      #1 fifo_full = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("stall_no_write", 32'(q.size()), 32'd3);
      fifo_full = 1'b0;
    end
    wait_bytes(5);
    @(posedge clk);
    #1;
    if (mode == 2) enable = 1'b0;
    pulse(s1);
    wait_bytes(9);
    if (mode == 2) begin
      chk("busy_before_csum", 32'(busy), 32'd1);
      @(posedge clk);
      #1 chk("busy_after_csum", 32'(busy), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pkt_len", 32'(q.size()), 32'd9);
    for (int i = 0; i < 9 && i < q.size(); i++)
      chk($sformatf("pkt_seq%0h_byte%0d", sq, i), 32'(q[i]), 32'(exp[i]));
    chk("seq_after_pkt", 32'(seq), 32'(nsq));
    chk("no_drops", 32'(drop_count), 32'd0);
    chk("idle_after_pkt", 32'(busy), 32'd0);
    enable = 1'b1;
  endtask

  initial begin
    tbl[0] = '{16'h1234, 16'h5678, 8'h16};
    tbl[1] = '{16'h0000, 16'h0000, 8'h03};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 8'h00};
    tbl[3] = '{16'h8001, 16'h7FFE, 8'h03};
    tbl[4] = '{16'hABCD, 16'h00EF, 8'h6D};
    rst_n = 1'b0; enable = 1'b0; pcm_valid = 1'b0; fifo_full = 1'b0; pcm_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_seq", 32'(seq), 32'd0);
    chk("post_rst_drop", 32'(drop_count), 32'd0);
    chk("post_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("post_rst_data", 32'(fifo_data), 32'd0);
    for (int i = 0; i < 5; i++)
      run_pkt(tbl[i].s0, tbl[i].s1, 8'(i), tbl[i].csum, 0);
    run_pkt(16'h1234, 16'h5678, 8'h05, 8'h1B, 1);
    run_pkt(16'h1234, 16'h5678, 8'h06, 8'h1C, 2);
    enable = 1'b0;
    pulse(16'hBEEF);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_discard_busy", 32'(busy), 32'd0);
    chk("idle_discard_drop", 32'(drop_count), 32'd0);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_discard_no_start", 32'(busy), 32'd0);
    for (int i = 7; i < 256; i++) begin
      logic [7:0] s8;
      s8 = 8'(i);
      run_pkt(16'h0000, 16'h0000, s8, s8 + 8'd2, 0);
    end
    run_pkt(16'h0000, 16'h0000, 8'h00, 8'h02, 0);
    q.delete();
    pulse(16'h1111);
    wait_bytes(5);
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(fifo_data), 32'd0);
    chk("mid_rst_seq", 32'(seq), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_writes", 32'(q.size()), 32'd5);
    chk("mid_rst_hold_empty", 32'(busy), 32'd0);
    run_pkt(16'h1234, 16'h5678, 8'h00, 8'h16, 0);
    q.delete();
    fifo_full = 1'b1;
    pulse(16'h4242);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      pulse(16'h1000 + 16'(i));
      @(posedge clk);
      #1;
    end
    chk("drop_three", 32'(drop_count), 32'd3);
    pcm_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1 pcm_valid = 1'b0;
    chk("drop_saturate", 32'(drop_count), 32'hFFFF);
    pulse(16'h2222);
    @(posedge clk);
    #1;
    chk("drop_stays_sat", 32'(drop_count), 32'hFFFF);
    chk("full_no_write", 32'(q.size()), 32'd0);
    chk("wr_while_full", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
